// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the PMP CSR block: CSR addresses and PMP config types.
package ibex_pkg;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
  localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
  localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
  localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
  localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
  localparam logic [11:0] CSR_PMPADDR1  = 12'h3B1;
  localparam logic [11:0] CSR_PMPADDR2  = 12'h3B2;
  localparam logic [11:0] CSR_PMPADDR3  = 12'h3B3;
  localparam logic [11:0] CSR_PMPADDR4  = 12'h3B4;
  localparam logic [11:0] CSR_PMPADDR5  = 12'h3B5;
  localparam logic [11:0] CSR_PMPADDR6  = 12'h3B6;
  localparam logic [11:0] CSR_PMPADDR7  = 12'h3B7;
  localparam logic [11:0] CSR_PMPADDR8  = 12'h3B8;
  localparam logic [11:0] CSR_PMPADDR9  = 12'h3B9;
  localparam logic [11:0] CSR_PMPADDR10 = 12'h3BA;
  localparam logic [11:0] CSR_PMPADDR11 = 12'h3BB;
  localparam logic [11:0] CSR_PMPADDR12 = 12'h3BC;
  localparam logic [11:0] CSR_PMPADDR13 = 12'h3BD;
  localparam logic [11:0] CSR_PMPADDR14 = 12'h3BE;
  localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
  localparam logic [11:0] CSR_MSECCFG   = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

endpackage

// File: rtl/ibex_pmp_csr_shadow_reg.sv
// Enabled register with reset value; with PMP_CSR_SHADOW_EN it keeps an inverted
// shadow copy and flags any bitwise disagreement on err_o.
module ibex_pmp_csr_shadow_reg #(
  parameter int unsigned       Width      = 32,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             err_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= ResetValue;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

`ifdef PMP_CSR_SHADOW_EN
  logic [Width-1:0] shadow_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= ~ResetValue;
    end else if (en_i) begin
      shadow_q <= ~d_i;
    end
  end

  assign err_o = |(q_o ^ ~shadow_q);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/ibex_pmp_csr_regs.sv
// PMP CSR state (pmpcfg, pmpaddr, mseccfg) with WARL, lock and Smepmp write rules.
// Define PMP_CSR_SHADOW_EN to add inverted shadow copies and a sticky mismatch flag.
module ibex_pmp_csr_regs import ibex_pkg::*; #(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_hit_o,
  output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o,
  output logic         csr_shadow_err_o
);

  function automatic logic [31:0] napot_ones_mask();
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) if (b + 2 <= int'(PMPGranularity)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] off_zeros_mask();
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) if (b < int'(PMPGranularity)) m[b] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] NapotOnesMask = napot_ones_mask();
  localparam logic [31:0] OffZerosMask  = off_zeros_mask();

  // WARL legalisation of a cfg byte that has already passed the lock/MML checks.
  function automatic pmp_cfg_t cfg_legalise(pmp_cfg_t c, logic mml);
    pmp_cfg_t r;
    r = c;
    if (!mml && c.write && !c.read) r.write = 1'b0;
    if (PMPGranularity >= 1 && c.mode == PMP_MODE_NA4) r.mode = PMP_MODE_OFF;
    return r;
  endfunction

  function automatic logic [31:0] addr_read(logic [31:0] a, pmp_cfg_mode_e m);
    if (m == PMP_MODE_NAPOT) return a | NapotOnesMask;
    else if (m == PMP_MODE_OFF || m == PMP_MODE_TOR) return a & ~OffZerosMask;
    else return a;
  endfunction

  pmp_cfg_t                 cfg_q  [PMPNumRegions];
  logic [31:0]              addr_q [PMPNumRegions];
  pmp_mseccfg_t             msec_q;
  pmp_mseccfg_t             msec_new;
  logic                     any_lock;
  logic [PMPNumRegions-1:0] cfg_err;
  logic [PMPNumRegions-1:0] addr_err;
  logic                     msec_err;

  always_comb begin
    any_lock = 1'b0;
    for (int i = 0; i < int'(PMPNumRegions); i++) any_lock = any_lock | cfg_q[i].lock;
  end

  for (genvar i = 0; i < PMPNumRegions; i++) begin : g_region
    localparam int unsigned ByteLsb = 8 * (i % 4);
    pmp_cfg_t cfg_new;
    logic     cfg_rej;
    logic     cfg_en;
    logic     addr_rej;
    logic     addr_en;

    assign cfg_new = {csr_wdata_i[ByteLsb+7], csr_wdata_i[ByteLsb+4 -: 5]};
    // M-mode executable locked rules may only be created while rlb is set.
    assign cfg_rej = (cfg_q[i].lock && !msec_q.rlb) ||
                     (msec_q.mml && !msec_q.rlb && cfg_new.lock &&
                      ((cfg_new.exec && !(cfg_new.read && cfg_new.write)) ||
                       (!cfg_new.read && cfg_new.write)));
    assign cfg_en  = csr_we_i && (csr_addr_i == CSR_PMPCFG0 + 12'(i / 4)) && !cfg_rej;

    if (i + 1 < PMPNumRegions) begin : g_tor
      assign addr_rej = (cfg_q[i].lock || (cfg_q[i+1].lock && cfg_q[i+1].mode == PMP_MODE_TOR))
                        && !msec_q.rlb;
    end else begin : g_last
      assign addr_rej = cfg_q[i].lock && !msec_q.rlb;
    end
    assign addr_en = csr_we_i && (csr_addr_i == CSR_PMPADDR0 + 12'(i)) && !addr_rej;

    ibex_pmp_csr_shadow_reg #(.Width($bits(pmp_cfg_t)), .ResetValue('0)) u_cfg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (cfg_en),
      .d_i   (cfg_legalise(cfg_new, msec_q.mml)),
      .q_o   (cfg_q[i]),
      .err_o (cfg_err[i])
    );

    ibex_pmp_csr_shadow_reg #(.Width(32), .ResetValue('0)) u_addr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (addr_en),
      .d_i   (csr_wdata_i),
      .q_o   (addr_q[i]),
      .err_o (addr_err[i])
    );

    assign csr_pmp_cfg_o[i]  = cfg_q[i];
    assign csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
  end

  // mml/mmwp are sticky; rlb can only be raised while nothing is locked.
  always_comb begin
    msec_new      = msec_q;
    msec_new.mml  = msec_q.mml | csr_wdata_i[0];
    msec_new.mmwp = msec_q.mmwp | csr_wdata_i[1];
    msec_new.rlb  = csr_wdata_i[2] & (msec_q.rlb | ~any_lock);
  end

  ibex_pmp_csr_shadow_reg #(.Width($bits(pmp_mseccfg_t)), .ResetValue('0)) u_msec (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (csr_we_i && csr_addr_i == CSR_MSECCFG),
    .d_i   (msec_new),
    .q_o   (msec_q),
    .err_o (msec_err)
  );

  assign csr_pmp_mseccfg_o = msec_q;

  assign csr_hit_o = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]) ||
                     (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]) ||
                     (csr_addr_i == CSR_MSECCFG) || (csr_addr_i == CSR_MSECCFGH);

  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < int'(PMPNumRegions); i++) begin
      if (csr_addr_i == CSR_PMPCFG0 + 12'(i / 4)) begin
        csr_rdata_o[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                     cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
      end
      if (csr_addr_i == CSR_PMPADDR0 + 12'(i)) begin
        csr_rdata_o = addr_read(addr_q[i], cfg_q[i].mode);
      end
    end
    if (csr_addr_i == CSR_MSECCFG) csr_rdata_o = {29'd0, msec_q};
  end

`ifdef PMP_CSR_SHADOW_EN
  logic shadow_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_err_q <= 1'b0;
    end else if ((|cfg_err) || (|addr_err) || msec_err) begin
      shadow_err_q <= 1'b1;
    end
  end

  assign csr_shadow_err_o = shadow_err_q;
`else
  assign csr_shadow_err_o = (|cfg_err) | (|addr_err) | msec_err;
`endif

endmodule
